upload_arbiter: RTL and testbench
=================================

UPLOAD_ARBITER -- requirements
Module: upload_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning the number of upload requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the number of cycles a granted source may stall mid-payload before abort.
REQ-003 SHALL have port clk, input, 1 bit: the single clock (PHY_CLK domain, 60 MHz).
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port src_data, input, NUM_SRC*8 bits: per-source payload bytes; source i occupies bits [8i+7:8i].
REQ-006 SHALL have port src_len, input, NUM_SRC*8 bits: per-source payload length, valid whenever src_req[i] is high.
REQ-007 SHALL have port src_req, input, NUM_SRC bits: source requests a frame; held until its grant.
REQ-008 SHALL have port src_valid, input, NUM_SRC bits: payload byte valid.
REQ-009 SHALL have port src_ready, output, NUM_SRC bits: payload byte accepted.
REQ-010 SHALL have port src_grant, output, NUM_SRC bits: one-hot, frame owner.
REQ-011 SHALL have port usb_upload_data, output, 8 bits: framed byte to USB CDC.
REQ-012 SHALL have port usb_upload_valid, output, 1 bit: byte valid.
REQ-013 SHALL have port usb_upload_ready, input, 1 bit: USB side accepts byte.
REQ-014 SHALL have port busy, output, 1 bit: frame in progress.
REQ-015 SHALL have port timeout_err, output, 1 bit: one-cycle pulse on payload abort.

Function
REQ-016 SHALL emit frame = 0xA5, source id, len, len payload bytes, checksum; checksum = XOR of id, len and all payload bytes.
REQ-017 SHALL transfer a byte only on usb_upload_valid && usb_upload_ready; data SHALL be held stable while valid && !ready.
REQ-018 SHALL use FSM IDLE -> SYNC -> ID -> LEN -> DATA -> CSUM -> IDLE; LEN goes directly to CSUM when len == 0.
REQ-019 SHALL, in IDLE with any src_req set, pick a source by round-robin starting at (last_grant+1) mod NUM_SRC, latch id and len, assert src_grant the next cycle, and enter SYNC.
REQ-020 SHALL NOT change grant, latched len or the round-robin pointer until the frame's CSUM byte transfers.
REQ-021 SHALL, in DATA, combinationally present src_data of the granted source as usb_upload_data; usb_upload_valid = src_valid[g]; src_ready[g] = usb_upload_ready; all other src_ready bits 0.
REQ-022 SHALL count payload bytes with an 8-bit counter and leave DATA after exactly len transfers.
REQ-023 SHALL count consecutive DATA cycles with src_valid[g] low; on reaching TIMEOUT it SHALL pad the remaining bytes with 0x00, including the pads in the checksum, and pulse timeout_err once.
REQ-024 SHALL have a latency of 1 cycle from src_req rise (arbiter IDLE) to usb_upload_valid high with 0xA5.
REQ-025 SHALL ignore src_req of a source that is released before its grant; there is no error.
REQ-026 SHALL treat simultaneous requests only via round-robin; no source may be granted twice while another is continuously requesting.
REQ-027 SHALL drive busy high in every state except IDLE.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-frame, immediately force state IDLE, all outputs 0, counters 0, round-robin pointer to NUM_SRC-1 (so source 0 wins first), and checksum 0.
REQ-029 SHALL NOT resume a partial frame after reset; the next frame starts with 0xA5.

Structure
REQ-030 SHALL place the FSM state encoding, SYNC_BYTE = 8'hA5 and the checksum rule in a shared package upload_pkg.
REQ-031 SHALL implement round-robin selection as the sub-module rr_arbiter (request vector, pointer -> one-hot grant, grant index).

Verification
REQ-032 SHALL cover single source 0, len 3, payload 11 22 33, ready=1: output A5 00 03 11 22 33 03 with valid contiguous.
REQ-033 SHALL cover sources 1 and 2 requesting together after reset, len 1 each: frame of source 1 fully, then source 2; grants never overlap.
REQ-034 SHALL cover len 2 with usb_upload_ready low for 5 cycles on the second payload byte: byte held stable, no duplicate, checksum correct.
REQ-035 SHALL cover len 4 where the source stops after 1 byte and TIMEOUT=16: 3 bytes of 0x00, one timeout_err pulse, and a correct checksum.
REQ-036 SHALL cover len 0 from source 3: output A5 03 00 03.
REQ-037 SHALL cover rst_n pulsed low during DATA: outputs 0 asynchronously, and the next request yields a fresh frame starting A5.

Source files
------------

// File: rtl/upload_pkg.sv
// Shared definitions for the upload arbiter: FSM encoding, sync byte, checksum rule.
package upload_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_ID   = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] PAD_BYTE  = 8'h00;

  // Running checksum: XOR accumulation of id, len and every payload (or pad) byte.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: the first requester after the pointer (wrapping) wins.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Pick the requester with the smallest rotational distance from ptr+1.
  always_comb begin
    int w_best;
    int w_dist;
    w_best  = N;
    w_dist  = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - 1 - int'(i_ptr)) % N;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_grant  = '0;
        o_grant[j] = 1'b1;
        o_idx    = W'(j);
        o_any    = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/upload_arbiter.sv
// Upload arbiter: frames one source's payload as A5, id, len, payload, checksum
// towards the USB CDC byte stream, arbitrating sources round-robin per frame.
module upload_arbiter
  import upload_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC*8-1:0] src_data,
  input  logic [NUM_SRC*8-1:0] src_len,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [NUM_SRC-1:0]   src_valid,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [NUM_SRC-1:0]   src_grant,
  output logic [7:0]           usb_upload_data,
  output logic                 usb_upload_valid,
  input  logic                 usb_upload_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_e             r_state, w_next;
  logic [IDX_W-1:0]   r_idx, r_ptr, w_rr_idx;
  logic [NUM_SRC-1:0] r_grant, w_rr_grant, w_ready;
  logic               w_rr_any;
  logic [7:0]         r_len, r_cnt, r_csum;
  logic [TO_W-1:0]    r_stall;
  logic               r_pad, r_timeout_err;
  logic [7:0]         w_data, w_src_byte, w_len_sel;
  logic               w_valid, w_src_valid, w_xfer, w_stall_hit;

  rr_arbiter #(.N(NUM_SRC), .W(IDX_W)) u_rr (
    .i_req   (src_req),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  // Select the granted source's byte/valid and the candidate's length.
  always_comb begin
    w_src_byte  = 8'h00;
    w_src_valid = 1'b0;
    w_len_sel   = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_src_byte  = src_data[8*i +: 8];
        w_src_valid = src_valid[i];
      end else begin
      end
      if (w_rr_idx == IDX_W'(i)) begin
        w_len_sel = src_len[8*i +: 8];
      end else begin
      end
    end
  end

  // Next state and byte-stream outputs; payload passes straight through in DATA.
  always_comb begin
    w_next  = r_state;
    w_data  = 8'h00;
    w_valid = 1'b0;
    w_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_rr_any) w_next = ST_SYNC;
        else          w_next = ST_IDLE;
      end
      ST_SYNC: begin
        w_data  = SYNC_BYTE;
        w_valid = 1'b1;
        if (usb_upload_ready) w_next = ST_ID;
        else                  w_next = ST_SYNC;
      end
      ST_ID: begin
        w_data  = 8'(r_idx);
        w_valid = 1'b1;
        if (usb_upload_ready) w_next = ST_LEN;
        else                  w_next = ST_ID;
      end
      ST_LEN: begin
        w_data  = r_len;
        w_valid = 1'b1;
        if (!usb_upload_ready)    w_next = ST_LEN;
        else if (r_len == 8'd0)   w_next = ST_CSUM;
        else                      w_next = ST_DATA;
      end
      ST_DATA: begin
        if (r_pad) begin
          w_data  = PAD_BYTE;
          w_valid = 1'b1;
        end else begin
          w_data  = w_src_byte;
          w_valid = w_src_valid;
          w_ready = r_grant & {NUM_SRC{usb_upload_ready}};
        end
        if (w_valid && usb_upload_ready && (r_cnt == r_len - 8'd1)) w_next = ST_CSUM;
        else                                                       w_next = ST_DATA;
      end
      ST_CSUM: begin
        w_data  = r_csum;
        w_valid = 1'b1;
        if (usb_upload_ready) w_next = ST_IDLE;
        else                  w_next = ST_CSUM;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_xfer      = w_valid & usb_upload_ready;
  assign w_stall_hit = (r_state == ST_DATA) && !r_pad && !w_src_valid &&
                       (r_stall == TO_W'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Frame context: grant, length, counters, checksum, stall/pad tracking, rr pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_ptr         <= IDX_W'(NUM_SRC - 1);
      r_grant       <= '0;
      r_len         <= 8'h00;
      r_cnt         <= 8'h00;
      r_csum        <= 8'h00;
      r_stall       <= '0;
      r_pad         <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rr_any) begin
            r_idx   <= w_rr_idx;
            r_grant <= w_rr_grant;
            r_len   <= w_len_sel;
            r_csum  <= csum_step(8'(w_rr_idx), w_len_sel);
            r_cnt   <= 8'h00;
            r_stall <= '0;
            r_pad   <= 1'b0;
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_cnt   <= r_cnt + 8'd1;
            r_csum  <= csum_step(r_csum, w_data);
            r_stall <= '0;
          end else if (w_stall_hit) begin
            r_pad         <= 1'b1;
            r_timeout_err <= 1'b1;
            r_stall       <= '0;
          end else if (!r_pad && !w_src_valid) begin
            r_stall <= r_stall + TO_W'(1);
          end else begin
            r_stall <= '0;
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            r_grant <= '0;
            r_ptr   <= r_idx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign src_grant        = r_grant;
  assign src_ready        = w_ready;
  assign usb_upload_data  = w_data;
  assign usb_upload_valid = w_valid;
  assign busy             = (r_state != ST_IDLE);
  assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_upload_arbiter.sv
// Scoreboard bench for upload_arbiter: a frame-level model predicts the byte stream.
module tb_upload_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*8-1:0] src_data, src_len;
  logic [N-1:0]   src_req, src_valid, src_ready, src_grant;
  logic [7:0]     usb_upload_data;
  logic           usb_upload_valid, usb_upload_ready, busy, timeout_err;

  always #5 clk = ~clk;

  upload_arbiter #(.NUM_SRC(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_len(src_len),
    .src_req(src_req), .src_valid(src_valid), .src_ready(src_ready),
    .src_grant(src_grant), .usb_upload_data(usb_upload_data),
    .usb_upload_valid(usb_upload_valid), .usb_upload_ready(usb_upload_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct { logic [7:0] b; int owner; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int m_ptr, exp_to, seen_to;
  int len_a[N], stop_a[N], p[N], stallc[N];
  logic [7:0] pl[N][8];
  int mode, lowcnt, cyc, ghost;
  logic lat_chk;
  logic [N-1:0] fire, gseen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: order pending requesters round-robin, build each frame from the rules.
  task automatic model_push(input logic [N-1:0] set);
    logic [N-1:0] pend;
    int sel;
    logic [7:0] cs, b;
    exp_t e;
    pend = set;
    while (pend != '0) begin
      sel = -1;
      for (int k = 1; k <= N; k++)
        if (sel < 0 && pend[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
      e.owner = sel;
      e.b = 8'hA5; exp_q.push_back(e);
      e.b = 8'(sel); exp_q.push_back(e);
      e.b = 8'(len_a[sel]); exp_q.push_back(e);
      cs = 8'(sel) ^ 8'(len_a[sel]);
      for (int j = 0; j < len_a[sel]; j++) begin
        b = (j < stop_a[sel]) ? pl[sel][j] : 8'h00;
        cs = cs ^ b;
        e.b = b; exp_q.push_back(e);
      end
      e.b = cs; exp_q.push_back(e);
      if (stop_a[sel] < len_a[sel]) exp_to++;
      m_ptr = sel;
      pend[sel] = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and checks handshake rules.
  initial begin
    logic prev_pend;
    logic [7:0] prev_data;
    exp_t e;
    prev_pend = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_pend = 1'b0;
      end else begin
        chk("grant_onehot", 32'($onehot0(src_grant)), 32'd1);
        chk("ready_only_owner", 32'(src_ready & ~src_grant), 32'd0);
        if (prev_pend) begin
          chk("hold_valid", 32'(usb_upload_valid), 32'd1);
          chk("hold_data", 32'(usb_upload_data), 32'(prev_data));
        end
        if (usb_upload_valid && usb_upload_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_byte actual=%0h required=none t=%0t", usb_upload_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'(usb_upload_data), 32'(e.b));
            chk("owner", 32'(src_grant), 32'(1) << e.owner);
            chk("busy_in_frame", 32'(busy), 32'd1);
          end
        end
        if (timeout_err) seen_to++;
        prev_pend = usb_upload_valid && !usb_upload_ready;
        prev_data = usb_upload_data;
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'(usb_upload_valid), 32'd0);
    chk({tag, "_data"},  32'(usb_upload_data), 32'd0);
    chk({tag, "_grant"}, 32'(src_grant), 32'd0);
    chk({tag, "_ready"}, 32'(src_ready), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_toerr"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    src_req = '0; src_valid = '0; src_data = '0; src_len = '0;
    usb_upload_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    exp_q.delete();
    m_ptr = N - 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int i, input int l, input int st);
    len_a[i] = l;
    stop_a[i] = st;
    for (int j = 0; j < 8; j++) pl[i][j] = 8'($urandom);
  endtask

  // One clock of source/sink behaviour: sample at negedge, update just after posedge.
  task automatic do_step();
    logic rdy;
    @(negedge clk);
    fire  = src_valid & src_ready;
    gseen = src_grant;
    if (lat_chk && cyc == 0) chk("idle_before_sync", 32'(usb_upload_valid), 32'd0);
    if (lat_chk && cyc == 1) begin
      chk("latency_valid", 32'(usb_upload_valid), 32'd1);
      chk("latency_sync", 32'(usb_upload_data), 32'hA5);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) p[i]++;
      if (gseen[i]) src_req[i] = 1'b0;
    end
    if (ghost >= 0 && cyc == 1) src_req[ghost] = 1'b1;
    if (ghost >= 0 && cyc == 2) src_req[ghost] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (src_valid[i] && !fire[i]) begin
        src_valid[i] = 1'b1;
      end else if (src_grant[i] && p[i] < len_a[i] && p[i] < stop_a[i]) begin
        if (mode != 1 || stallc[i] >= 3 || $urandom_range(0, 4) != 0) begin
          src_valid[i] = 1'b1;
          src_data[i*8 +: 8] = pl[i][p[i]];
          stallc[i] = 0;
        end else begin
          src_valid[i] = 1'b0;
          stallc[i]++;
        end
      end else begin
        src_valid[i] = 1'b0;
      end
    end
    rdy = 1'b1;
    if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
    if (mode == 2) begin
      for (int i = 0; i < N; i++)
        if (src_grant[i] && p[i] == 1 && lowcnt < 5) rdy = 1'b0;
      if (!rdy) lowcnt++;
    end
    usb_upload_ready = rdy;
    cyc++;
  endtask

  task automatic run_scen(input logic [N-1:0] set, input int md, input int gh,
                          input logic lat, input logic rmid);
    logic done, hit;
    mode = md; ghost = gh; lat_chk = lat; lowcnt = 0; cyc = 0;
    exp_to = 0; seen_to = 0;
    for (int i = 0; i < N; i++) begin
      p[i] = 0; stallc[i] = 0;
      src_len[i*8 +: 8] = 8'(len_a[i]);
    end
    model_push(set);
    usb_upload_ready = (md != 1) ? 1'b1 : 1'b0;
    src_req = set;
    done = 1'b0;
    while (!done) begin
      do_step();
      hit = 1'b0;
      if (rmid)
        for (int i = 0; i < N; i++) if (src_grant[i] && p[i] >= 2) hit = 1'b1;
      if (hit) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("async_reset");
        exp_q.delete();
        m_ptr = N - 1;
        src_req = '0; src_valid = '0; usb_upload_ready = 1'b0;
        done = 1'b1;
      end else if (exp_q.size() == 0 && !busy && src_req == '0) begin
        done = 1'b1;
      end else if (cyc >= 3000) begin
        checks++; failures++;
        $display("FAIL scenario_budget actual=%0d_bytes_left required=0", exp_q.size());
        done = 1'b1;
      end
    end
    if (!rmid) begin
      chk("timeout_pulses", 32'(seen_to), 32'(exp_to));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("idle_after", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int g;
    logic [N-1:0] set;
    for (int i = 0; i < N; i++) cfg(i, 0, 99);
    reset_dut();

    // Single source 0, payload 11 22 33, ideal sink: A5 00 03 11 22 33 03.
    cfg(0, 3, 99);
    pl[0][0] = 8'h11; pl[0][1] = 8'h22; pl[0][2] = 8'h33;
    run_scen(4'b0001, 0, -1, 1'b1, 1'b0);

    // Sources 1 and 2 together after reset: source 1 first.
    reset_dut();
    cfg(1, 1, 99); cfg(2, 1, 99);
    run_scen(4'b0110, 0, -1, 1'b0, 1'b0);

    // Sink stalls 5 cycles on the second payload byte.
    cfg(0, 2, 99);
    run_scen(4'b0001, 2, -1, 1'b0, 1'b0);

    // Source stops after one byte: three pads and one timeout pulse.
    cfg(2, 4, 1);
    run_scen(4'b0100, 0, -1, 1'b0, 1'b0);

    // Empty payload from source 3: A5 03 00 03.
    cfg(3, 0, 99);
    run_scen(4'b1000, 0, -1, 1'b0, 1'b0);

    // Reset mid-payload, then a fresh frame.
    cfg(1, 5, 99);
    run_scen(4'b0010, 1, -1, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cfg(2, 2, 99);
    run_scen(4'b0100, 0, -1, 1'b1, 1'b0);

    // Randomised mixes of requesters, lengths, stalls, stops and ghost requests.
    for (int it = 0; it < 40; it++) begin
      set = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        cfg(i, $urandom_range(0, 6), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : 99);
      g = $urandom_range(0, N - 1);
      if (set[g]) g = -1;
      run_scen(set, 1, g, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
